// File: rtl/irq_ctrl.sv
// Interrupt controller: latches rising edges on peripheral lines, masks and prioritises them,
// and presents a single registered request to the CU with ack / end-of-interrupt handshake.
//
// state | meaning
// IDLE  | nothing presented; picks the lowest eligible index when any line is eligible
// REQ   | hwint asserted for irq_id; waits for ack, or withdraws if that line loses eligibility
// SVC   | acknowledged source in service; waits for eoi, new edges keep latching
module irq_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_in,
  output logic [NUM_IRQ-1:0] mask,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] ovr,
  input  logic               ovr_clr,
  output logic               hwint,
  input  logic               ack,
  output logic [ID_W-1:0]    irq_id,
  input  logic               eoi,
  output logic               in_svc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] ovr_q, ovr_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic               hwint_q, in_svc_q;

  logic [NUM_IRQ-1:0] edge_v;
  logic [NUM_IRQ-1:0] elig;
  logic [NUM_IRQ-1:0] clr_vec;
  logic [ID_W-1:0]    winner;
  logic               ack_take;

  assign edge_v = irq & ~irq_q;
  assign elig   = pending_q & mask_q;

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) winner = ID_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    ack_take = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (elig != '0) begin
          state_d  = ST_REQ;
          irq_id_d = winner;
        end
      end
      ST_REQ: begin
        if (ack) begin
          state_d  = ST_SVC;
          ack_take = 1'b1;
        end else if (!elig[irq_id_q]) begin
          state_d = ST_IDLE;
        end
      end
      ST_SVC: begin
        if (eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new edge on the acknowledged line in the same cycle must survive the clear.
  always_comb begin
    clr_vec = '0;
    if (ack_take) clr_vec[irq_id_q] = 1'b1;
    pending_d = (pending_q & ~clr_vec) | edge_v;
    ovr_d     = (ovr_clr ? '0 : ovr_q) | (edge_v & pending_q);
    mask_d    = mask_wr ? mask_in : mask_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      irq_id_q  <= '0;
      hwint_q   <= 1'b0;
      in_svc_q  <= 1'b0;
      irq_q     <= '0;
      pending_q <= '0;
      ovr_q     <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      irq_id_q  <= irq_id_d;
      hwint_q   <= (state_d == ST_REQ);
      in_svc_q  <= (state_d == ST_SVC);
      irq_q     <= irq;
      pending_q <= pending_d;
      ovr_q     <= ovr_d;
      mask_q    <= mask_d;
    end
  end

  assign mask    = mask_q;
  assign pending = pending_q;
  assign ovr     = ovr_q;
  assign hwint   = hwint_q;
  assign irq_id  = irq_id_q;
  assign in_svc  = in_svc_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus randomized traffic checked against a
// cycle-level model of the interrupt-delivery rules.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] irq = 8'h00;
  logic       mask_wr = 1'b0;
  logic [7:0] mask_in = 8'h00;
  logic [7:0] mask, pending, ovr;
  logic       ovr_clr = 1'b0;
  logic       hwint;
  logic       ack = 1'b0;
  logic [2:0] irq_id;
  logic       eoi = 1'b0;
  logic       in_svc;

  int n_cmp = 0;
  int n_bad = 0;

  irq_ctrl #(.NUM_IRQ(8)) dut (
    .clk(clk), .rst(rst), .irq(irq), .mask_wr(mask_wr), .mask_in(mask_in),
    .mask(mask), .pending(pending), .ovr(ovr), .ovr_clr(ovr_clr),
    .hwint(hwint), .ack(ack), .irq_id(irq_id), .eoi(eoi), .in_svc(in_svc)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = nothing presented, 1 = presenting, 2 = serving.
  bit [7:0] m_prev, m_pend, m_ovr, m_mask;
  int       m_phase, m_id;

  function automatic int lowest(bit [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_pend = 0; m_ovr = 0; m_mask = 0; m_phase = 0; m_id = 0;
  endtask

  task automatic tick();
    bit [7:0] e, el, clr;
    int np, nid;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      e = irq & ~m_prev;
      el = m_pend & m_mask;
      clr = 0; np = m_phase; nid = m_id;
      if (m_phase == 0) begin
        if (el != 0) begin np = 1; nid = lowest(el); end
      end else if (m_phase == 1) begin
        if (ack) begin np = 2; clr[m_id] = 1'b1; end
        else if (!el[m_id]) np = 0;
      end else if (eoi) begin
        np = 0;
      end
      m_ovr  = (ovr_clr ? 8'h00 : m_ovr) | (e & m_pend);
      m_pend = (m_pend & ~clr) | e;
      if (mask_wr) m_mask = mask_in;
      m_prev = irq; m_phase = np; m_id = nid;
    end
    #1;
  endtask

  task automatic write_mask(input logic [7:0] v);
    mask_wr = 1; mask_in = v; tick(); mask_wr = 0;
  endtask

  task automatic test_reset();
    #2 rst = 1; #1;
    n_cmp++; if (hwint !== 1'b0) begin n_bad++; $display("FAIL reset_hwint: got %b want 0", hwint); end
    n_cmp++; if ({pending, ovr, mask} !== 24'h0) begin n_bad++; $display("FAIL reset_regs: got %h want 000000", {pending, ovr, mask}); end
    n_cmp++; if ({irq_id, in_svc} !== 4'h0) begin n_bad++; $display("FAIL reset_id_svc: got %h want 0", {irq_id, in_svc}); end
    repeat (2) @(posedge clk);
    #1 rst = 0; model_reset();
    tick();
    n_cmp++; if ({hwint, pending} !== 9'h0) begin n_bad++; $display("FAIL reset_idle: got %h want 000", {hwint, pending}); end
  endtask

  task automatic test_single();
    write_mask(8'hFF);
    n_cmp++; if (mask !== 8'hFF) begin n_bad++; $display("FAIL single_mask: got %h want ff", mask); end
    irq = 8'h08; tick(); irq = 8'h00;
    n_cmp++; if (pending !== 8'h08) begin n_bad++; $display("FAIL single_pend: got %h want 08", pending); end
    n_cmp++; if (hwint !== 1'b0) begin n_bad++; $display("FAIL single_hw_early: got %b want 0", hwint); end
    tick();
    n_cmp++; if ({hwint, irq_id} !== {1'b1, 3'd3}) begin n_bad++; $display("FAIL single_req: got %b/%0d want 1/3", hwint, irq_id); end
    ack = 1; tick(); ack = 0;
    n_cmp++; if ({pending, hwint, in_svc} !== {8'h00, 1'b0, 1'b1}) begin n_bad++; $display("FAIL single_ack: got %h/%b/%b want 00/0/1", pending, hwint, in_svc); end
    eoi = 1; tick(); eoi = 0;
    n_cmp++; if ({hwint, in_svc} !== 2'b00) begin n_bad++; $display("FAIL single_eoi: got %b%b want 00", hwint, in_svc); end
  endtask

  task automatic test_priority();
    irq = 8'h24; tick(); irq = 8'h00; tick();
    n_cmp++; if ({hwint, irq_id} !== {1'b1, 3'd2}) begin n_bad++; $display("FAIL prio_first: got %b/%0d want 1/2", hwint, irq_id); end
    ack = 1; tick(); ack = 0;
    eoi = 1; tick(); eoi = 0;
    n_cmp++; if ({hwint, in_svc, pending} !== {2'b00, 8'h20}) begin n_bad++; $display("FAIL prio_eoi: got %h want 020", {hwint, in_svc, pending}); end
    tick();
    n_cmp++; if ({hwint, irq_id} !== {1'b1, 3'd5}) begin n_bad++; $display("FAIL prio_second: got %b/%0d want 1/5", hwint, irq_id); end
    ack = 1; tick(); ack = 0;
    eoi = 1; tick(); eoi = 0;
  endtask

  task automatic test_mask();
    write_mask(8'h00);
    irq = 8'h02; tick(); irq = 8'h00; tick();
    n_cmp++; if ({hwint, pending} !== {1'b0, 8'h02}) begin n_bad++; $display("FAIL mask_blocked: got %b/%h want 0/02", hwint, pending); end
    write_mask(8'h02);
    n_cmp++; if ({mask, hwint} !== {8'h02, 1'b0}) begin n_bad++; $display("FAIL mask_write: got %h/%b want 02/0", mask, hwint); end
    tick();
    n_cmp++; if ({hwint, irq_id} !== {1'b1, 3'd1}) begin n_bad++; $display("FAIL mask_enable: got %b/%0d want 1/1", hwint, irq_id); end
    write_mask(8'h00);
    n_cmp++; if (hwint !== 1'b1) begin n_bad++; $display("FAIL mask_hold: got %b want 1", hwint); end
    tick();
    n_cmp++; if ({hwint, pending} !== {1'b0, 8'h02}) begin n_bad++; $display("FAIL mask_withdraw: got %b/%h want 0/02", hwint, pending); end
    write_mask(8'hFF); tick();
    ack = 1; tick(); ack = 0;
    eoi = 1; tick(); eoi = 0;
  endtask

  task automatic test_overrun();
    irq = 8'h10; tick(); irq = 8'h00; tick();
    irq = 8'h10; tick(); irq = 8'h00;
    n_cmp++; if ({ovr, pending, hwint} !== {8'h10, 8'h10, 1'b1}) begin n_bad++; $display("FAIL ovr_set: got %h/%h/%b want 10/10/1", ovr, pending, hwint); end
    ovr_clr = 1; tick(); ovr_clr = 0;
    n_cmp++; if (ovr !== 8'h00) begin n_bad++; $display("FAIL ovr_clr: got %h want 00", ovr); end
    ack = 1; tick(); ack = 0;
    n_cmp++; if ({pending, in_svc} !== {8'h00, 1'b1}) begin n_bad++; $display("FAIL ovr_ack: got %h/%b want 00/1", pending, in_svc); end
    eoi = 1; tick(); eoi = 0;
  endtask

  task automatic test_ack_collision();
    irq = 8'h01; tick(); irq = 8'h00; tick();
    n_cmp++; if ({hwint, irq_id} !== {1'b1, 3'd0}) begin n_bad++; $display("FAIL coll_req: got %b/%0d want 1/0", hwint, irq_id); end
    ack = 1; irq = 8'h01; tick(); ack = 0; irq = 8'h00;
    n_cmp++; if ({pending, in_svc, hwint} !== {8'h01, 2'b10}) begin n_bad++; $display("FAIL coll_pend: got %h/%b/%b want 01/1/0", pending, in_svc, hwint); end
    eoi = 1; tick(); eoi = 0;
    n_cmp++; if ({hwint, in_svc} !== 2'b00) begin n_bad++; $display("FAIL coll_eoi: got %b%b want 00", hwint, in_svc); end
    tick();
    n_cmp++; if ({hwint, irq_id} !== {1'b1, 3'd0}) begin n_bad++; $display("FAIL coll_rereq: got %b/%0d want 1/0", hwint, irq_id); end
    ack = 1; tick(); ack = 0;
    eoi = 1; tick(); eoi = 0;
  endtask

  task automatic test_reset_midreq();
    irq = 8'h81; tick(); irq = 8'h00; tick();
    n_cmp++; if ({hwint, pending} !== {1'b1, 8'h81}) begin n_bad++; $display("FAIL rstreq_pre: got %b/%h want 1/81", hwint, pending); end
    rst = 1; #1;
    model_reset();
    n_cmp++; if ({hwint, pending, irq_id, mask, in_svc} !== 21'h0) begin n_bad++; $display("FAIL rstreq_clear: got %h want 0", {hwint, pending, irq_id, mask, in_svc}); end
    irq = 8'h40; tick(); tick();
    rst = 0;
    tick();
    n_cmp++; if (pending !== 8'h40) begin n_bad++; $display("FAIL rstreq_rel_edge: got %h want 40", pending); end
    irq = 8'h00; tick();
  endtask

  task automatic test_random();
    logic [28:0] got, want;
    for (int c = 0; c < 800; c++) begin
      irq     = irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      ack     = (m_phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      eoi     = (m_phase == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      ovr_clr = ($urandom_range(0, 15) == 0);
      mask_wr = ($urandom_range(0, 11) == 0);
      mask_in = ($urandom_range(0, 3) == 0) ? m_mask : 8'($urandom);
      tick();
      got  = {pending, ovr, mask, hwint, in_svc, irq_id};
      want = {m_pend, m_ovr, m_mask, (m_phase == 1), (m_phase == 2), 3'(m_id)};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL rand_c%0d: got pend=%h ovr=%h mask=%h hw=%b svc=%b id=%0d want pend=%h ovr=%h mask=%h hw=%b svc=%b id=%0d",
                 c, got[28:21], got[20:13], got[12:5], got[4], got[3], got[2:0],
                 want[28:21], want[20:13], want[12:5], want[4], want[3], want[2:0]);
      end
    end
    irq = 0; ack = 0; eoi = 0; ovr_clr = 0; mask_wr = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_overrun();
    test_ack_collision();
    test_reset_midreq();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
